// File: rtl/mem_traffic_gen_pkg.sv
// mem_traffic_pkg: mode, state and op encodings shared by the traffic generator
package mem_traffic_pkg;
  localparam logic [1:0] MODE_IL = 2'd0;
  localparam logic [1:0] MODE_WR_RD = 2'd1;
  localparam logic [1:0] MODE_RD = 2'd2;
  localparam logic [1:0] MODE_WR = 2'd3;
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_NEXT, S_FIN} state_t;
endpackage

// File: rtl/mem_traffic_gen_if.sv
// mem_traffic_gen_if: request/response bus between the traffic generator and the memory model
interface mem_traffic_gen_if #(parameter int WD = 32, parameter int WA = 20);
  logic [WA-1:0] mem_a;
  logic mem_re, mem_we;
  logic [WD-1:0] mem_d, mem_q;
  logic mem_busy, mem_done;
  modport master (output mem_a, mem_re, mem_we, mem_d, input mem_q, mem_busy, mem_done);
  modport slave (input mem_a, mem_re, mem_we, mem_d, output mem_q, mem_busy, mem_done);
endinterface

// File: rtl/mem_traffic_gen_seq.sv
// mtg_seq: walks index/phase and generates op, address, pattern data and last flag
module mtg_seq
  import mem_traffic_pkg::*;
#(parameter int WD = 32, parameter int WA = 20, parameter int WC = 16, parameter int SEED = 1) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          adv,
  input  logic [1:0]    mode,
  input  logic [WA-1:0] base,
  input  logic [WA-1:0] stride,
  input  logic [WC-1:0] len,
  output logic          op,
  output logic [WA-1:0] addr,
  output logic [WD-1:0] data,
  output logic          last
);
  logic [1:0] mode_r;
  logic [WA-1:0] base_r, stride_r;
  logic [WC-1:0] len_r, i;
  logic ph, end_i;
  assign end_i = i == len_r - WC'(1);
  assign last = end_i && (mode_r[1] || ph);
  assign op = mode_r == MODE_RD ? OP_RD : mode_r == MODE_WR ? OP_WR : ph ? OP_RD : OP_WR;
  // address and data are stepped incrementally so no multiplier is needed for BASE + i*STRIDE
  always_ff @(posedge clk)
    if (rst) begin
      mode_r <= '0;
      base_r <= '0;
      stride_r <= '0;
      len_r <= '0;
      i <= '0;
      ph <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (load) begin
      mode_r <= mode;
      base_r <= base;
      stride_r <= stride;
      len_r <= len;
      i <= '0;
      ph <= 1'b0;
      addr <= base;
      data <= WD'(SEED);
    end else if (adv) begin
      if (mode_r == MODE_IL && !ph) ph <= 1'b1;
      else if (mode_r == MODE_WR_RD && !ph && end_i) begin
        ph <= 1'b1;
        i <= '0;
        addr <= base_r;
        data <= WD'(SEED);
      end else begin
        ph <= mode_r == MODE_IL ? 1'b0 : ph;
        i <= i + WC'(1);
        addr <= addr + stride_r;
        data <= data + WD'(1);
      end
    end
endmodule

// File: rtl/mem_traffic_gen.sv
// mem_traffic_gen: handshake FSM, watchdog, read checker and counters around the op sequencer
module mem_traffic_gen
  import mem_traffic_pkg::*;
#(parameter int WD = 32, parameter int WA = 20, parameter int WC = 16,
  parameter int TIMEOUT_CYC = 1024, parameter int SEED = 1) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [WA-1:0]     base,
  input  logic [WA-1:0]     stride,
  input  logic [WC-1:0]     len,
  mem_traffic_gen_if.master bus,
  output logic              done,
  output logic              timeout,
  output logic [WC-1:0]     err_cnt,
  output logic [WA-1:0]     first_err_a,
  output logic [WC-1:0]     acc_cnt
);
  localparam int WT = $clog2(TIMEOUT_CYC + 1);
  state_t state, next;
  logic req, op, last, go, act, cmpl, tmo, mis;
  logic [WT-1:0] wd;
  logic [WA-1:0] addr;
  logic [WD-1:0] exp_d;
  assign go = state == S_IDLE && start;
  assign act = state == S_REQ || state == S_WAIT;
  assign cmpl = act && bus.mem_done;
  assign tmo = act && !bus.mem_done && wd == WT'(TIMEOUT_CYC - 1);
  assign mis = cmpl && op == OP_RD && bus.mem_q != exp_d;
  assign bus.mem_re = req && op == OP_RD;
  assign bus.mem_we = req && op == OP_WR;
  assign bus.mem_a = addr;
  assign bus.mem_d = exp_d;
  mtg_seq #(.WD(WD), .WA(WA), .WC(WC), .SEED(SEED)) u_seq (
    .clk(clk), .rst(rst), .load(go), .adv(state == S_NEXT && !last),
    .mode(mode), .base(base), .stride(stride), .len(len),
    .op(op), .addr(addr), .data(exp_d), .last(last)
  );
  // state register
  always_ff @(posedge clk)
    if (rst) state <= S_IDLE;
    else state <= next;
  // next state: completion beats busy, watchdog beats everything but completion
  always_comb begin
    next = state;
    case (state)
      S_IDLE: next = !start ? S_IDLE : len == '0 ? S_FIN : S_REQ;
      S_REQ: next = bus.mem_done ? S_NEXT : tmo ? S_FIN : bus.mem_busy ? S_WAIT : S_REQ;
      S_WAIT: next = bus.mem_done ? S_NEXT : tmo ? S_FIN : S_WAIT;
      S_NEXT: next = last ? S_FIN : S_REQ;
      default: next = S_IDLE;
    endcase
  end
  // request, watchdog, status flags and counters; DONE rises as FIN is entered
  always_ff @(posedge clk)
    if (rst) begin
      req <= 1'b0;
      wd <= '0;
      done <= 1'b0;
      timeout <= 1'b0;
      err_cnt <= '0;
      acc_cnt <= '0;
      first_err_a <= '0;
    end else begin
      req <= next == S_REQ;
      wd <= act ? wd + WT'(1) : '0;
      done <= next == S_FIN || (done && !go);
      timeout <= tmo || (timeout && !go);
      acc_cnt <= go ? '0 : acc_cnt + WC'(cmpl);
      err_cnt <= go ? '0 : err_cnt + WC'(mis && err_cnt != '1);
      first_err_a <= go ? '0 : mis && err_cnt == '0 ? addr : first_err_a;
    end
endmodule

// File: tb/tb_mem_traffic_gen.sv
// tb_mem_traffic_gen: directed checks of sequencing modes, read checker, watchdog and edge cases
module tb_mem_traffic_gen;
  logic clk = 0, rst = 1, start = 0;
  logic [1:0] mode = 0;
  logic [19:0] base = 0, stride = 0;
  logic [15:0] len = 0;
  logic done, timeout;
  logic [15:0] err_cnt, acc_cnt;
  logic [19:0] first_err_a;
  int passed = 0, total = 0;
  logic [1:0] slv = 0;
  int cnt;
  logic [19:0] la;
  logic [31:0] mem [256];
  logic poke = 0, clr = 0;
  logic [19:0] poke_a = 0;
  logic [31:0] poke_d = 0;
  int n;
  logic lwe [300];
  logic [19:0] lad [300];
  logic [31:0] ldd [300];
  logic [7:0] k;
  mem_traffic_gen_if #(.WD(32), .WA(20)) bus ();
  mem_traffic_gen #(.WD(32), .WA(20), .WC(16), .TIMEOUT_CYC(16), .SEED(1)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base(base), .stride(stride), .len(len),
    .bus(bus), .done(done), .timeout(timeout), .err_cnt(err_cnt),
    .first_err_a(first_err_a), .acc_cnt(acc_cnt)
  );
  always #5 clk = ~clk;
  // memory model: slv 0 answers in the request cycle, 1 accepts then completes 3 cycles later, 2 is mute
  assign k = slv == 2'd0 ? bus.mem_a[9:2] : la[9:2];
  assign bus.mem_busy = slv == 2'd1 && (bus.mem_re || bus.mem_we);
  assign bus.mem_done = (slv == 2'd0 && (bus.mem_re || bus.mem_we)) || (slv == 2'd1 && cnt == 3);
  assign bus.mem_q = mem[k];
  always @(posedge clk) begin
    if (rst) cnt <= 0;
    else if (slv == 2'd1 && (bus.mem_re || bus.mem_we)) begin
      cnt <= 1;
      la <= bus.mem_a;
    end else if (cnt != 0) cnt <= cnt == 3 ? 0 : cnt + 1;
    if (poke) mem[poke_a[9:2]] <= poke_d;
    else if (!rst && bus.mem_we && slv != 2'd2) mem[bus.mem_a[9:2]] <= bus.mem_d;
    if (clr || rst) n <= 0;
    else if ((bus.mem_re || bus.mem_we) && n < 300) begin
      lwe[n] <= bus.mem_we;
      lad[n] <= bus.mem_a;
      ldd[n] <= bus.mem_d;
      n <= n + 1;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic run(logic [1:0] m, logic [19:0] b, logic [19:0] s, logic [15:0] l);
    mode = m;
    base = b;
    stride = s;
    len = l;
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic wait_done(string tag, int max);
    int c = 0;
    while (!done && c < max) begin
      tick();
      c++;
    end
    chk(tag, done, 1);
  endtask
  task automatic clear_log();
    clr = 1;
    tick();
    clr = 0;
  endtask
  task automatic store(logic [19:0] a, logic [31:0] d);
    poke_a = a;
    poke_d = d;
    poke = 1;
    tick();
    poke = 0;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_acc", acc_cnt, 0);
    chk("rst_ferr", first_err_a, 0);
    chk("rst_re", bus.mem_re, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_a", bus.mem_a, 0);
    chk("rst_d", bus.mem_d, 0);
    rst = 0;
    tick();
    // mode 0, 129 interleaved pairs against the zero-latency slave
    slv = 0;
    run(2'd0, 20'h0, 20'h4, 16'd129);
    chk("m0_first_we", bus.mem_we, 1);
    chk("m0_first_d", bus.mem_d, 1);
    wait_done("m0_done", 1000);
    chk("m0_acc", acc_cnt, 258);
    chk("m0_err", err_cnt, 0);
    chk("m0_timeout", timeout, 0);
    chk("m0_n", n, 258);
    chk("m0_lastw_op", lwe[256], 1);
    chk("m0_lastw_a", lad[256], 32'h200);
    chk("m0_lastw_d", ldd[256], 32'h81);
    chk("m0_lastr_op", lwe[257], 0);
    chk("m0_lastr_a", lad[257], 32'h200);
    tick();
    tick();
    chk("m0_done_sticky", done, 1);
    // mode 1 against the busy-then-done slave
    clear_log();
    slv = 1;
    run(2'd1, 20'h100, 20'h4, 16'd8);
    wait_done("m1_done", 400);
    chk("m1_acc", acc_cnt, 16);
    chk("m1_err", err_cnt, 0);
    chk("m1_n", n, 16);
    for (int i = 0; i < 16; i++) chk("m1_order", lwe[i], i < 8);
    chk("m1_w7_a", lad[7], 32'h11c);
    chk("m1_r0_a", lad[8], 32'h100);
    // mode 2 read check with one corrupted word
    slv = 0;
    store(20'h0, 32'd1);
    store(20'h4, 32'd2);
    store(20'h8, 32'hdead);
    store(20'hc, 32'd4);
    clear_log();
    run(2'd2, 20'h0, 20'h4, 16'd4);
    wait_done("m2_done", 100);
    chk("m2_err", err_cnt, 1);
    chk("m2_ferr", first_err_a, 8);
    chk("m2_acc", acc_cnt, 4);
    chk("m2_n", n, 4);
    chk("m2_op", lwe[0], 0);
    // address wrap in write-only mode
    clear_log();
    run(2'd3, 20'hffffc, 20'h4, 16'd3);
    wait_done("wrap_done", 100);
    chk("wrap_n", n, 3);
    chk("wrap_a0", lad[0], 32'hffffc);
    chk("wrap_a1", lad[1], 32'h0);
    chk("wrap_a2", lad[2], 32'h4);
    chk("wrap_d2", ldd[2], 3);
    chk("wrap_err", err_cnt, 0);
    // mute slave: watchdog fires on the 16th outstanding cycle
    slv = 2;
    clear_log();
    run(2'd2, 20'h0, 20'h4, 16'd2);
    chk("to_re_first", bus.mem_re, 1);
    repeat (15) tick();
    chk("to_early_timeout", timeout, 0);
    chk("to_early_done", done, 0);
    chk("to_early_re", bus.mem_re, 1);
    tick();
    chk("to_timeout", timeout, 1);
    chk("to_done", done, 1);
    chk("to_re", bus.mem_re, 0);
    chk("to_acc", acc_cnt, 0);
    // LEN=0 finishes with no requests
    slv = 0;
    clear_log();
    run(2'd0, 20'h0, 20'h4, 16'd0);
    chk("len0_done", done, 1);
    chk("len0_timeout", timeout, 0);
    chk("len0_re", bus.mem_re, 0);
    chk("len0_we", bus.mem_we, 0);
    tick();
    chk("len0_n", n, 0);
    chk("len0_acc", acc_cnt, 0);
    // reset while waiting on the second transaction
    slv = 1;
    clear_log();
    run(2'd3, 20'h40, 20'h4, 16'd4);
    repeat (6) tick();
    chk("rw_pre_acc", acc_cnt, 1);
    chk("rw_pre_a", bus.mem_a, 32'h44);
    chk("rw_pre_we", bus.mem_we, 0);
    rst = 1;
    tick();
    chk("rw_acc", acc_cnt, 0);
    chk("rw_a", bus.mem_a, 0);
    chk("rw_d", bus.mem_d, 0);
    chk("rw_we", bus.mem_we, 0);
    chk("rw_done", done, 0);
    rst = 0;
    tick();
    // START re-pulsed mid-run is ignored
    clear_log();
    run(2'd3, 20'h40, 20'h4, 16'd4);
    repeat (3) tick();
    mode = 2'd2;
    base = 20'h0;
    len = 16'd1;
    start = 1;
    tick();
    start = 0;
    wait_done("rp_done", 200);
    chk("rp_acc", acc_cnt, 4);
    chk("rp_n", n, 4);
    chk("rp_op", lwe[3], 1);
    chk("rp_a", lad[3], 32'h4c);
    chk("rp_d", ldd[3], 4);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
